// File: rtl/qracc_tile_sequencer_pkg.sv
// Shared types for the QR accelerator tile sequencer: FSM state encoding and
// the configuration snapshot taken when a pass starts.
package qracc_tile_sequencer_pkg;

  localparam int unsigned CFG_FL_W   = 3;
  localparam int unsigned CFG_TILE_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_ISSUE,
    ST_WAIT,
    ST_SCALE,
    ST_WRITE,
    ST_DONE
  } tile_seq_state_t;

  typedef struct packed {
    logic [CFG_TILE_W-1:0] num_tiles;
    logic [CFG_FL_W:0]     loads;
  } tile_seq_cfg_t;

  // Rows per tile: zero means one row, anything above the loader depth is capped.
  function automatic logic [CFG_FL_W:0] clamp_loads(input logic [CFG_FL_W:0] raw);
    logic [CFG_FL_W:0] max_l;
    max_l = {1'b1, {CFG_FL_W{1'b0}}};
    if (raw == '0)
      return {{CFG_FL_W{1'b0}}, 1'b1};
    else if (raw > max_l)
      return max_l;
    else
      return raw;
  endfunction

endpackage

// File: rtl/qracc_addr_gen.sv
// Base/stride address accumulator: load captures base and stride, step adds
// the stride (modulo 2^addrWidth), clear returns to zero.
module qracc_addr_gen #(
  parameter int unsigned addrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic [addrWidth-1:0] i_base,
  input  logic [addrWidth-1:0] i_stride,
  output logic [addrWidth-1:0] o_addr
);

  logic [addrWidth-1:0] r_addr;
  logic [addrWidth-1:0] r_stride;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_stride <= '0;
    end else if (i_clear) begin
      r_addr   <= '0;
      r_stride <= '0;
    end else if (i_load) begin
      r_addr   <= i_base;
      r_stride <= i_stride;
    end else if (i_step) begin
      r_addr   <= r_addr + r_stride;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/qracc_tile_sequencer.sv
// Sequences one QR accelerator layer pass tile by tile: buffer rows into the
// feature loader, one MAC handshake, scaler settle, then one output write.
module qracc_tile_sequencer
  import qracc_tile_sequencer_pkg::*;
#(
  parameter int unsigned addrWidth     = 32,
  parameter int unsigned flAddrWidth   = 3,
  parameter int unsigned tileCountBits = 16,
  parameter int unsigned scalerLatency = 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     start_i,
  input  logic                     clear_i,
  input  logic [tileCountBits-1:0] cfg_num_tiles_i,
  input  logic [flAddrWidth:0]     cfg_loads_i,
  input  logic [addrWidth-1:0]     cfg_rd_base_i,
  input  logic [addrWidth-1:0]     cfg_rd_stride_i,
  input  logic [addrWidth-1:0]     cfg_wr_base_i,
  input  logic [addrWidth-1:0]     cfg_wr_stride_i,
  output logic                     buf_rd_en_o,
  output logic [addrWidth-1:0]     buf_rd_addr_o,
  output logic                     fl_wr_en_o,
  output logic [flAddrWidth-1:0]   fl_addr_o,
  output logic                     mac_valid_o,
  input  logic                     mac_ready_i,
  input  logic                     mac_done_i,
  output logic                     buf_wr_en_o,
  output logic [addrWidth-1:0]     buf_wr_addr_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [tileCountBits-1:0] tile_idx_o,
  output logic                     err_o
);

  localparam logic [2:0] SCL_LAT = 3'(scalerLatency);

  tile_seq_state_t          r_state;
  tile_seq_state_t          w_nxt_state;
  tile_seq_cfg_t            r_cfg;
  logic [flAddrWidth-1:0]   r_k;
  logic [2:0]               r_scl;
  logic [tileCountBits-1:0] r_tile;
  logic                     r_rd_en;
  logic                     r_fl_wr_en;
  logic [flAddrWidth-1:0]   r_fl_addr;
  logic                     r_mac_valid;
  logic                     r_wr_en;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;

  logic                     w_start;
  logic                     w_last_row;
  logic [tileCountBits-1:0] w_tile_inc;
  logic                     w_last_tile;

  assign w_start     = start_i && !clear_i && (r_state == ST_IDLE);
  assign w_last_row  = (({1'b0, r_k} + 1'b1) == r_cfg.loads);
  assign w_tile_inc  = r_tile + 1'b1;
  assign w_last_tile = (w_tile_inc == r_cfg.num_tiles);

  always_comb begin
    w_nxt_state = r_state;
    if (clear_i) begin
      w_nxt_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start_i) w_nxt_state = (cfg_num_tiles_i == '0) ? ST_DONE : ST_LOAD;
        ST_LOAD:  if (w_last_row) w_nxt_state = ST_DRAIN;
        ST_DRAIN: w_nxt_state = ST_ISSUE;
        // mac_valid_o is high for the whole of ISSUE, so ready alone completes the transfer
        ST_ISSUE: if (mac_ready_i) w_nxt_state = ST_WAIT;
        ST_WAIT:  if (mac_done_i) w_nxt_state = (SCL_LAT == 3'd0) ? ST_WRITE : ST_SCALE;
        ST_SCALE: if ((r_scl + 3'd1) == SCL_LAT) w_nxt_state = ST_WRITE;
        ST_WRITE: w_nxt_state = w_last_tile ? ST_DONE : ST_LOAD;
        ST_DONE:  w_nxt_state = ST_IDLE;
        default:  w_nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_state     <= ST_IDLE;
      r_cfg       <= '0;
      r_k         <= '0;
      r_scl       <= '0;
      r_tile      <= '0;
      r_rd_en     <= 1'b0;
      r_fl_wr_en  <= 1'b0;
      r_fl_addr   <= '0;
      r_mac_valid <= 1'b0;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_rd_en     <= (w_nxt_state == ST_LOAD);
      r_mac_valid <= (w_nxt_state == ST_ISSUE);
      r_wr_en     <= (w_nxt_state == ST_WRITE);
      r_done      <= (w_nxt_state == ST_DONE);
      r_busy      <= (w_nxt_state != ST_IDLE);
      // Loader write trails the buffer read by its one-cycle latency
      r_fl_wr_en  <= r_rd_en && !clear_i;
      r_fl_addr   <= r_k;
      r_k         <= ((r_state == ST_LOAD) && (w_nxt_state == ST_LOAD)) ? r_k + 1'b1 : '0;
      r_scl       <= (r_state == ST_SCALE) ? r_scl + 3'd1 : 3'd0;

      if (w_start) begin
        r_cfg.num_tiles <= cfg_num_tiles_i;
        r_cfg.loads     <= clamp_loads(cfg_loads_i);
        r_tile          <= '0;
      end else if ((r_state == ST_WRITE) && !clear_i && !w_last_tile) begin
        r_tile <= w_tile_inc;
      end

      if (mac_done_i && (r_state != ST_WAIT))
        r_err <= 1'b1;
      else if (w_start)
        r_err <= 1'b0;
    end
  end

  // Row pointer runs contiguously across tiles; write pointer steps once per tile
  qracc_addr_gen #(.addrWidth(addrWidth)) u_rd_gen (
    .clk      (clk),
    .rst      (nrst),
    .i_clear  (clear_i),
    .i_load   (w_start),
    .i_step   (r_state == ST_LOAD),
    .i_base   (cfg_rd_base_i),
    .i_stride (cfg_rd_stride_i),
    .o_addr   (buf_rd_addr_o)
  );

  qracc_addr_gen #(.addrWidth(addrWidth)) u_wr_gen (
    .clk      (clk),
    .rst      (nrst),
    .i_clear  (clear_i),
    .i_load   (w_start),
    .i_step   (r_state == ST_WRITE),
    .i_base   (cfg_wr_base_i),
    .i_stride (cfg_wr_stride_i),
    .o_addr   (buf_wr_addr_o)
  );

  assign buf_rd_en_o = r_rd_en;
  assign fl_wr_en_o  = r_fl_wr_en;
  assign fl_addr_o   = r_fl_addr;
  assign mac_valid_o = r_mac_valid;
  assign buf_wr_en_o = r_wr_en;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign tile_idx_o  = r_tile;
  assign err_o       = r_err;

endmodule

// File: tb/tb_qracc_tile_sequencer.sv
// Directed and randomized passes of the tile sequencer against a cycle-level
// event model derived from the per-tile timing formula.
module tb_qracc_tile_sequencer;

  localparam int SL = 1;

  logic        clk;
  logic        nrst;
  logic        start_i;
  logic        clear_i;
  logic [15:0] cfg_num_tiles_i;
  logic [3:0]  cfg_loads_i;
  logic [31:0] cfg_rd_base_i;
  logic [31:0] cfg_rd_stride_i;
  logic [31:0] cfg_wr_base_i;
  logic [31:0] cfg_wr_stride_i;
  logic        buf_rd_en_o;
  logic [31:0] buf_rd_addr_o;
  logic        fl_wr_en_o;
  logic [2:0]  fl_addr_o;
  logic        mac_valid_o;
  logic        mac_ready_i;
  logic        mac_done_i;
  logic        buf_wr_en_o;
  logic [31:0] buf_wr_addr_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] tile_idx_o;
  logic        err_o;

  qracc_tile_sequencer #(
    .addrWidth     (32),
    .flAddrWidth   (3),
    .tileCountBits (16),
    .scalerLatency (SL)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .start_i         (start_i),
    .clear_i         (clear_i),
    .cfg_num_tiles_i (cfg_num_tiles_i),
    .cfg_loads_i     (cfg_loads_i),
    .cfg_rd_base_i   (cfg_rd_base_i),
    .cfg_rd_stride_i (cfg_rd_stride_i),
    .cfg_wr_base_i   (cfg_wr_base_i),
    .cfg_wr_stride_i (cfg_wr_stride_i),
    .buf_rd_en_o     (buf_rd_en_o),
    .buf_rd_addr_o   (buf_rd_addr_o),
    .fl_wr_en_o      (fl_wr_en_o),
    .fl_addr_o       (fl_addr_o),
    .mac_valid_o     (mac_valid_o),
    .mac_ready_i     (mac_ready_i),
    .mac_done_i      (mac_done_i),
    .buf_wr_en_o     (buf_wr_en_o),
    .buf_wr_addr_o   (buf_wr_addr_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .tile_idx_o      (tile_idx_o),
    .err_o           (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  ev_t exp_rd[$], got_rd[$];
  ev_t exp_fl[$], got_fl[$];
  ev_t exp_wr[$], got_wr[$];
  ev_t exp_dn[$], got_dn[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input ev_t e[$], input ev_t g[$]);
    int n;
    chk({tag, "_count"}, 64'(g.size()), 64'(e.size()));
    n = (g.size() < e.size()) ? g.size() : e.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d]_cycle", tag, i), 64'(g[i].cyc), 64'(e[i].cyc));
      chk($sformatf("%s[%0d]_a", tag, i), 64'(g[i].a), 64'(e[i].a));
      chk($sformatf("%s[%0d]_b", tag, i), 64'(g[i].b), 64'(e[i].b));
    end
  endtask

  function automatic ev_t mk(input int c, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.cyc = c;
    e.a   = a;
    e.b   = b;
    return e;
  endfunction

  // One full pass: the model lists every expected event with its cycle
  // (cycle 0 = the edge that samples start_i), the loop plays seq_acc.
  task automatic run_pass(input string tag, input int n, input int ld,
                          input logic [31:0] rb, input logic [31:0] rs,
                          input logic [31:0] wb, input logic [31:0] ws,
                          input int r_lat, input int d_lat);
    int L, s, row, h, w, done_cyc, cyc, vcnt, done_at, issues, valid_cycles, post;
    bit seen_done;
    exp_rd.delete(); got_rd.delete(); exp_fl.delete(); got_fl.delete();
    exp_wr.delete(); got_wr.delete(); exp_dn.delete(); got_dn.delete();

    L = (ld == 0) ? 1 : ((ld > 8) ? 8 : ld);
    s = 1;
    row = 0;
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < L; k++) begin
        exp_rd.push_back(mk(s + k, rb + rs * 32'(row), 32'd0));
        exp_fl.push_back(mk(s + k + 1, 32'(k), 32'd0));
        row++;
      end
      h = s + L + 1 + r_lat;
      w = h + d_lat + 1 + SL;
      exp_wr.push_back(mk(w, wb + ws * 32'(t), 32'(t)));
      s = w + 1;
    end
    done_cyc = (n == 0) ? 1 : s;
    exp_dn.push_back(mk(done_cyc, 32'd0, 32'd0));

    @(negedge clk);
    cfg_num_tiles_i = 16'(n);
    cfg_loads_i     = 4'(ld);
    cfg_rd_base_i   = rb;
    cfg_rd_stride_i = rs;
    cfg_wr_base_i   = wb;
    cfg_wr_stride_i = ws;
    start_i     = 1'b1;
    mac_ready_i = 1'b0;
    mac_done_i  = 1'b0;
    cyc = 0; vcnt = 0; done_at = -1; issues = 0; valid_cycles = 0; post = 0;
    seen_done = 1'b0;

    while (cyc < done_cyc + 20 && post < 3) begin
      @(posedge clk);
      #1;
      cyc++;
      start_i = 1'b0;
      if (buf_rd_en_o) got_rd.push_back(mk(cyc, buf_rd_addr_o, 32'd0));
      if (fl_wr_en_o)  got_fl.push_back(mk(cyc, 32'(fl_addr_o), 32'd0));
      if (buf_wr_en_o) got_wr.push_back(mk(cyc, buf_wr_addr_o, 32'(tile_idx_o)));
      if (done_o) begin
        got_dn.push_back(mk(cyc, 32'd0, 32'd0));
        seen_done = 1'b1;
      end
      if (seen_done) post++;
      mac_done_i = (cyc == done_at);
      mac_ready_i = 1'b0;
      if (mac_valid_o) begin
        valid_cycles++;
        vcnt++;
        if (vcnt > r_lat) begin
          mac_ready_i = 1'b1;
          issues++;
          done_at = cyc + d_lat;
          vcnt = 0;
        end
      end
    end
    mac_ready_i = 1'b0;
    mac_done_i  = 1'b0;

    chk({tag, "_finished"}, 64'(seen_done), 64'd1);
    cmp_q({tag, "_rd"}, exp_rd, got_rd);
    cmp_q({tag, "_fl"}, exp_fl, got_fl);
    cmp_q({tag, "_wr"}, exp_wr, got_wr);
    cmp_q({tag, "_done"}, exp_dn, got_dn);
    chk({tag, "_issues"}, 64'(issues), 64'(n));
    chk({tag, "_valid_cycles"}, 64'(valid_cycles), 64'(n * (r_lat + 1)));
    chk({tag, "_busy_after"}, 64'(busy_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
  endtask

  function automatic logic any_out();
    return |{buf_rd_en_o, buf_rd_addr_o, fl_wr_en_o, fl_addr_o, mac_valid_o,
             buf_wr_en_o, buf_wr_addr_o, busy_o, done_o, tile_idx_o, err_o};
  endfunction

  initial begin
    int seen;
    nrst = 1'b1;
    start_i = 1'b0;
    clear_i = 1'b0;
    mac_ready_i = 1'b0;
    mac_done_i = 1'b0;
    cfg_num_tiles_i = '0;
    cfg_loads_i = '0;
    cfg_rd_base_i = '0;
    cfg_rd_stride_i = '0;
    cfg_wr_base_i = '0;
    cfg_wr_stride_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(any_out()), 64'd0);
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_outputs", 64'(any_out()), 64'd0);

    run_pass("single",  1, 3, 32'h100, 32'd4, 32'h800, 32'h20, 0, 5);
    run_pass("four",    4, 3, 32'h100, 32'd4, 32'h800, 32'h20, 0, 2);
    run_pass("backpr",  1, 2, 32'h40,  32'd8, 32'h900, 32'd4,  7, 3);
    run_pass("zero_n",  0, 3, 32'h100, 32'd4, 32'h800, 32'h20, 0, 1);
    run_pass("zero_l",  3, 0, 32'h200, 32'd4, 32'h300, 32'd4,  1, 1);
    run_pass("wrap",    1, 3, 32'hFFFFFFFC, 32'd4, 32'h0, 32'd4, 0, 1);
    run_pass("clamp",   2, 12, 32'h1000, 32'h10, 32'h2000, 32'h8, 2, 2);
    for (int i = 0; i < 6; i++)
      run_pass($sformatf("rand%0d", i), int'($urandom_range(1, 3)), int'($urandom_range(0, 15)),
               $urandom, $urandom, $urandom, $urandom,
               int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));

    // Abort while waiting for the accumulator result
    @(negedge clk);
    cfg_num_tiles_i = 16'd1;
    cfg_loads_i = 4'd2;
    start_i = 1'b1;
    mac_ready_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      if (mac_valid_o) seen = 1;
    end
    chk("abort_reached_issue", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    mac_ready_i = 1'b0;
    chk("abort_in_wait_busy", 64'(busy_o), 64'd1);
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    chk("abort_idle_busy", 64'(busy_o), 64'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (buf_wr_en_o || done_o || busy_o) seen++;
    end
    chk("abort_no_write_done", 64'(seen), 64'd0);

    // Stray accumulator result in IDLE, then a start clears the flag
    mac_done_i = 1'b1;
    @(posedge clk);
    #1;
    mac_done_i = 1'b0;
    chk("stray_done_err", 64'(err_o), 64'd1);
    cfg_num_tiles_i = 16'd0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("start_clears_err", 64'(err_o), 64'd0);
    @(posedge clk);
    #1;

    // Abort on the first read suppresses the trailing loader write
    cfg_num_tiles_i = 16'd1;
    cfg_loads_i = 4'd3;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("abort_load_rd_en", 64'(buf_rd_en_o), 64'd1);
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    chk("abort_load_fl_suppressed", 64'(fl_wr_en_o), 64'd0);
    chk("abort_load_rd_off", 64'(buf_rd_en_o), 64'd0);
    chk("abort_load_busy", 64'(busy_o), 64'd0);

    // Start and clear together: clear wins
    start_i = 1'b1;
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    clear_i = 1'b0;
    chk("start_clear_busy", 64'(busy_o), 64'd0);
    chk("start_clear_rd", 64'(buf_rd_en_o), 64'd0);

    // Asynchronous reset in the middle of LOAD
    cfg_num_tiles_i = 16'd2;
    cfg_loads_i = 4'd4;
    cfg_rd_base_i = 32'h500;
    cfg_rd_stride_i = 32'd4;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk("midload_rd_en", 64'(buf_rd_en_o), 64'd1);
    #2;
    nrst = 1'b1;
    #1;
    chk("async_reset_outputs", 64'(any_out()), 64'd0);
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    chk("after_reset_idle", 64'(busy_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
